// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: source count,
// register word offsets, control/status bit positions.
package irq_pkg;

  localparam int NSRC = 6;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_MASK   = 3'd1;
  localparam logic [2:0] OFF_MODE   = 3'd2;
  localparam logic [2:0] OFF_PEND   = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam int GE_BIT   = 0;
  localparam int STAT_VLD = 31;

  function automatic logic [2:0] lowest_idx(
    input logic [NSRC-1:0] v
  );
    lowest_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = i[2:0];
    end
  endfunction

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: previous-sample register, pending bit,
// level/edge set logic and write-1-to-clear with set priority.
module irq_src_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic i_src,
  input  logic i_mode,
  input  logic i_clr,
  output logic o_pend
);

  logic r_prev;
  logic r_pend;
  logic w_set;

  assign w_set  = i_mode ? (i_src & ~r_prev) : i_src;
  assign o_pend = r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_prev <= i_src;
      r_pend <= w_set | (r_pend & ~i_clr);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: CTRL/MASK/MODE registers, per-source cells,
// priority encoder and combinational read mux.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC = irq_pkg::NSRC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [29:0]     addr,
  input  logic            we,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  output logic [NSRC-1:0] hwint
);

  logic            r_ge;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_mode;

  logic [2:0]      w_off;
  logic [NSRC-1:0] w_pend;
  logic [NSRC-1:0] w_act;
  logic [NSRC-1:0] w_clr;
  logic [31:0]     w_dout;
  logic            w_unused;

  assign w_off    = addr[2:0];
  assign w_act    = w_pend & r_mask;
  assign hwint    = r_ge ? w_act : '0;
  assign w_clr    = (we && w_off == OFF_PEND) ? din[NSRC-1:0] : '0;
  assign w_unused = ^{addr[29:3], din[31:NSRC]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ge   <= 1'b0;
      r_mask <= '0;
      r_mode <= '0;
    end else if (we) begin
      case (w_off)
        OFF_CTRL: r_ge   <= din[GE_BIT];
        OFF_MASK: r_mask <= din[NSRC-1:0];
        OFF_MODE: r_mode <= din[NSRC-1:0];
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    irq_src_cell u_cell (
      .clk    (clk),
      .rst_n  (reset),
      .i_src  (src[g]),
      .i_mode (r_mode[g]),
      .i_clr  (w_clr[g]),
      .o_pend (w_pend[g])
    );
  end

  always_comb begin
    w_dout = '0;
    case (w_off)
      OFF_CTRL: w_dout[GE_BIT]   = r_ge;
      OFF_MASK: w_dout[NSRC-1:0] = r_mask;
      OFF_MODE: w_dout[NSRC-1:0] = r_mode;
      OFF_PEND: w_dout[NSRC-1:0] = w_pend;
      OFF_STATUS: begin
        w_dout[STAT_VLD] = (|w_act) & r_ge;
        w_dout[2:0]      = lowest_idx(w_act);
      end
      default: ;
    endcase
  end

  assign dout = w_dout;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed-vector bench for irq_ctrl with hand-computed
// expected register and hwint values.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src;
  logic [29:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic [5:0]  hwint;

  int tests = 0;
  int fails = 0;

  irq_ctrl #(.NSRC(6)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .hwint (hwint)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    addr = {27'd0, off};
    din  = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
    din  = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] off,
                    input logic [31:0] exp);
    addr = {27'd0, off};
    #1;
    chk(tag, dout, exp);
  endtask

  initial begin
    reset = 1'b0;
    src   = '0;
    addr  = '0;
    we    = 1'b0;
    din   = '0;
    #1;
    chk("rst_hwint", {26'd0, hwint}, 32'h0);
    rd("rst_ctrl", 3'd0, 32'h0);
    rd("rst_pend", 3'd3, 32'h0);
    rd("rst_stat", 3'd4, 32'h0);
    step();
    step();
    reset = 1'b1;
    step();

    // level pulse then W1C
    wr(3'd1, 32'h3F);
    wr(3'd0, 32'h1);
    wr(3'd2, 32'h0);
    rd("mask_rb", 3'd1, 32'h3F);
    src = 6'h01;
    step();
    src = 6'h00;
    chk("lat1_hwint", {26'd0, hwint}, 32'h01);
    step();
    chk("hold_hwint", {26'd0, hwint}, 32'h01);
    rd("stat_idx0", 3'd4, 32'h8000_0000);
    wr(3'd3, 32'h01);
    chk("w1c_hwint", {26'd0, hwint}, 32'h00);

    // edge mode on src[2]
    wr(3'd2, 32'h04);
    rd("mode_rb", 3'd2, 32'h04);
    src = 6'h04;
    for (int i = 0; i < 10; i++) step();
    rd("edge_once", 3'd3, 32'h04);
    wr(3'd3, 32'h04);
    rd("edge_w1c", 3'd3, 32'h00);
    step();
    step();
    rd("edge_held", 3'd3, 32'h00);
    src = 6'h00;
    step();
    src = 6'h04;
    step();
    rd("edge_rise2", 3'd3, 32'h04);
    src = 6'h00;
    step();
    src = 6'h04;
    step();
    rd("edge_coal", 3'd3, 32'h04);
    src = 6'h00;
    wr(3'd3, 32'h04);
    rd("edge_clr", 3'd3, 32'h00);

    // level held: W1C loses to set
    wr(3'd2, 32'h00);
    src = 6'h02;
    step();
    rd("lvl_set", 3'd3, 32'h02);
    wr(3'd3, 32'h02);
    rd("lvl_w1c_held", 3'd3, 32'h02);
    src = 6'h00;
    wr(3'd3, 32'h02);
    rd("lvl_clr", 3'd3, 32'h00);

    // edge rise and W1C in the same cycle
    wr(3'd2, 32'h04);
    src = 6'h04;
    wr(3'd3, 32'h04);
    rd("edge_setwin", 3'd3, 32'h04);
    src = 6'h00;
    wr(3'd3, 32'h04);
    rd("edge_clr2", 3'd3, 32'h00);

    // masked sources still latch
    wr(3'd2, 32'h00);
    wr(3'd1, 32'h00);
    src = 6'h05;
    step();
    rd("msk_pend", 3'd3, 32'h05);
    chk("msk_hwint", {26'd0, hwint}, 32'h00);
    rd("msk_stat", 3'd4, 32'h0);
    wr(3'd1, 32'h04);
    chk("m4_hwint", {26'd0, hwint}, 32'h04);
    rd("m4_stat", 3'd4, 32'h8000_0002);
    wr(3'd0, 32'h0);
    chk("ge0_hwint", {26'd0, hwint}, 32'h00);
    rd("ge0_stat", 3'd4, 32'h0000_0002);
    wr(3'd0, 32'h1);

    // write returns old value in the same cycle
    addr = 30'd1;
    din  = 32'h3F;
    we   = 1'b1;
    #1;
    chk("wr_old", dout, 32'h04);
    step();
    we = 1'b0;
    rd("wr_new", 3'd1, 32'h3F);

    // reset mid-operation
    src = 6'h07;
    step();
    rd("pre_pend", 3'd3, 32'h07);
    chk("pre_hwint", {26'd0, hwint}, 32'h07);
    #3;
    reset = 1'b0;
    #1;
    chk("async_hwint", {26'd0, hwint}, 32'h00);
    rd("ar_pend", 3'd3, 32'h0);
    src = 6'h00;
    step();
    reset = 1'b1;
    step();
    for (int o = 0; o < 8; o++) begin
      rd($sformatf("post_off%0d", o), o[2:0], 32'h0);
    end
    for (int o = 5; o < 8; o++) wr(o[2:0], 32'hFFFF_FFFF);
    rd("nw_ctrl", 3'd0, 32'h0);
    rd("nw_mask", 3'd1, 32'h0);
    rd("nw_mode", 3'd2, 32'h0);
    rd("nw_off7", 3'd7, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 6, number of interrupt sources; fixed at 6 in this CPU.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; clears all state immediately.
REQ-004 src  in  6  level interrupt requests: bit0 TC0 IRQ, bit1 TC1 IRQ, bit2 external interrupt, bits5:3 spare.
REQ-005 addr  in  30  bridge word address (byte address [31:2]); only addr[2:0] is decoded.
REQ-006 we  in  1  bridge write strobe, already qualified by the bridge's 0x7F20–0x7F3F select.
REQ-007 din  in  32  bridge write data.
REQ-008 dout  out  32  read data, combinational from addr.
REQ-009 hwint  out  6  masked pending vector to CPU CP0 HWInt.

Function
REQ-010 SHALL implement registers by word offset: 0 CTRL (bit0 GE, RW); 1 MASK[5:0] RW; 2 MODE[5:0] RW (0 = level, 1 = rising edge); 3 PEND[5:0] RO, write-1-to-clear; 4 STATUS RO.
REQ-011 Unused register bits SHALL read 0; offsets 5–7 SHALL read 0 and ignore writes.
REQ-012 SHALL keep a per-source previous-sample register prev, updated from src every cycle.
REQ-013 Edge mode: PEND[i] SHALL set at the edge after a cycle with src[i]=1 and prev[i]=0; it SHALL then hold until cleared, regardless of src.
REQ-014 Level mode: PEND[i] SHALL set at every edge where src[i]=1; a W1C while src[i] is still 1 SHALL leave it set.
REQ-015 Set and W1C on the same bit in the same cycle: set SHALL win.
REQ-016 A repeated edge on an already-pending bit SHALL coalesce, with no count kept.
REQ-017 MASK and MODE SHALL NOT gate PEND capture; masked sources still latch.
REQ-018 Writing MODE SHALL NOT alter PEND or prev.
REQ-019 hwint SHALL equal PEND & MASK when GE=1, and 0 otherwise; it is combinational from registers.
REQ-020 Latency SHALL be 1 cycle: src sampled high at edge n gives hwint high after edge n (GE and mask set).
REQ-021 STATUS SHALL be: bit31 = |(PEND & MASK) & GE; bits[2:0] = lowest index set in PEND & MASK, or 0 when none.
REQ-022 Register writes SHALL take effect at the clock edge; a read at the same offset in the same cycle SHALL return the old value.

Reset
REQ-023 When reset=0: CTRL, MASK, MODE, PEND and prev SHALL be 0, and hwint SHALL be 0 without waiting for a clock edge.
REQ-024 Reset asserted mid-operation SHALL discard pending state; after reset releases, a src already high SHALL register in edge mode only after it falls and rises again.
REQ-025 During reset, dout SHALL reflect the reset register values.

Structure
REQ-026 Package irq_pkg SHALL hold: NSRC, the register offsets (CTRL/MASK/MODE/PEND/STATUS), the GE bit index, and the STATUS valid-bit index.
REQ-027 SHALL use one sub-module, irq_src_cell (per source: prev, PEND bit, set/W1C logic), generated NSRC times.
REQ-028 Priority encoding and the read mux SHALL live in irq_ctrl; no other state is permitted.
REQ-029 Target size: 120–250 RTL lines.

Verification
REQ-030 Reset release; write MASK=0x3F, CTRL=1, MODE=0; pulse src=0x01 for 1 cycle -> hwint=0x01 next cycle; src drops -> hwint=0x00 only after W1C PEND=0x01.
REQ-031 MODE=0x04; hold src[2]=1 for 10 cycles -> PEND=0x04 once; W1C 0x04 while held -> PEND=0; second rise -> PEND=0x04.
REQ-032 Level mode with src[1] held high; W1C 0x02 -> PEND stays 0x02; the same-cycle set+clear case holds set.
REQ-033 MASK=0x00, src=0x05 -> PEND=0x05, hwint=0; write MASK=0x04 -> hwint=0x04, STATUS=0x80000002.
REQ-034 PEND=0x07 with GE=1; assert reset between edges -> hwint=0 immediately; after release all regs read 0 and offsets 5–7 read 0.
